clk_div_meter: RTL and testbench

//   Measures one output of the cascaded clock divider against the system clock.
//   One measurement captures the period and high time of the sampled divider output, both in clk cycles.
//   It then flags a pass/fail against an expected period.

---
 rtl/clk_div_meter.sv | 136 +++++++++++++
 tb/tb_clk_div_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period and high time of one divider output in clk
// cycles and flags pass/fail against an expected period.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | results held; waiting for start
// ARM   | measurement running; waiting for the first rising edge
// MEAS  | counting from the first rise; capture fall, then next rise
// DONE  | one-cycle result strobe; pass/timeout/period/high_time valid
module clk_div_meter #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 16,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             pass,
  output logic             timeout
);

  // The counter must reach TIMEOUT-1 without wrapping.
  if (TIMEOUT >= (1 << CNT_W) || TIMEOUT < 2) begin : g_bad_timeout
    $error("clk_div_meter: TIMEOUT must be in [2, 2**CNT_W)");
  end

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_C    = (CNT_W+1)'(TOL);

  state_t             state, state_nxt;
  logic               s_meta, s_sync, s_dly;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]     diff_abs;
  logic               period_ok;

  assign rise     = s_sync & ~s_dly;
  assign fall     = ~s_sync & s_dly;
  assign cnt_last = (cnt == CNT_LAST);

  // One bit of headroom keeps the difference from wrapping for any count.
  assign diff      = $signed({1'b0, cnt}) - $signed({1'b0, EXP_C});
  assign diff_abs  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign period_ok = (diff_abs <= TOL_C);

  assign busy = (state == ARM) || (state == MEAS);
  assign done = (state == DONE);

  // Two-flop synchroniser plus a delay flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_dly  <= 1'b0;
    end else begin
      s_meta <= sig_in;
      s_sync <= s_meta;
      s_dly  <= s_sync;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a rise on the last counted cycle still wins over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ARM;
      ARM: begin
        if (rise)          state_nxt = MEAS;
        else if (cnt_last) state_nxt = DONE;
      end
      MEAS: if (rise || cnt_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle counter and result registers; results hold outside a measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      period    <= '0;
      high_time <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            period    <= '0;
            high_time <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt_last) timeout <= 1'b1;
          end
        end
        MEAS: begin
          cnt <= cnt + CNT_W'(1);
          if (fall) high_time <= cnt;
          if (rise) begin
            period <= cnt;
            pass   <= period_ok;
          end else if (cnt_last) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_clk_div_meter;

  localparam int CNT_W   = 16;
  localparam int EXP_P   = 16;
  localparam int TOL     = 1;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, pass, timeout;
  logic [CNT_W-1:0] period, high_time;

  clk_div_meter #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP_P), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .period(period), .high_time(high_time),
    .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high_time;
    int pass;
    int timeout;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   passes = 0;

  // pattern: 0 periodic (pat_p cycles, high for pat_h), 1 held low, 2 held high
  int pat_mode = 1;
  int pat_p    = 16;
  int pat_h    = 8;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference model: the result follows directly from the waveform shape.
  function automatic exp_t model(input int p, input int h, input int mode);
    exp_t e;
    int   d;
    if (mode == 0) begin
      d = p - EXP_P;
      if (d < 0) d = -d;
      e.period = p; e.high_time = h; e.timeout = 0;
      e.pass = (d <= TOL) ? 1 : 0;
    end else begin
      e.period = 0; e.high_time = 0; e.timeout = 1; e.pass = 0;
    end
    return e;
  endfunction

  // Pattern generator, updates away from the sampling edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      case (pat_mode)
        0: begin
          if (ph >= pat_p) ph = 0;
          sig_in = (ph < pat_h);
          ph++;
        end
        1: sig_in = 1'b0;
        default: sig_in = 1'b1;
      endcase
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got a done pulse, required none");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("period",    period,    e.period);
          check("high_time", high_time, e.high_time);
          check("pass",      pass,      e.pass);
          check("timeout",   timeout,   e.timeout);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  // mode 0 periodic, 2 held low (timeout), 3 rise once then stuck high
  task automatic measure(input int p, input int h, input int mode,
                         input bit extra_starts, output int lat);
    bit found;
    bit last_busy;
    found = 0;
    lat = -1;
    last_busy = 0;
    if (mode == 0) begin
      pat_p = p; pat_h = h; pat_mode = 0;
      repeat (2 * p + 6) @(negedge clk);
    end else begin
      pat_mode = 1;
      repeat (6) @(negedge clk);
    end
    last_exp = model(p, h, mode);
    sb_q.push_back(last_exp);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 0) check("busy_after_start", busy, 1);
      if (extra_starts && (j == 3 || j == 5)) start = 1'b1;
      if (mode == 3 && j == 4) pat_mode = 2;
      if (done) begin
        found = 1;
        lat = j;
        check("busy_before_done", last_busy, 1);
        break;
      end
      last_busy = busy;
    end
    start = 1'b0;
    if (!found) begin
      checks++;
      $display("FAIL done_wait: got no done in 300 cycles, required a done");
    end
    repeat (4) @(negedge clk);
    check("hold_period",  period,  last_exp.period);
    check("hold_pass",    pass,    last_exp.pass);
    check("hold_timeout", timeout, last_exp.timeout);
    check("idle_busy",    busy,    0);
  endtask

  initial begin
    int lat;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // square wave at the expected period
    measure(16, 8, 0, 0, lat);
    check("lat_le_35", (lat <= 35) ? 1 : 0, 1);
    // narrow pulse, high 2 of every 16
    measure(16, 2, 0, 0, lat);
    // tolerance boundaries
    measure(18, 9, 0, 0, lat);
    measure(17, 5, 0, 0, lat);
    measure(15, 7, 0, 0, lat);
    measure(14, 3, 0, 0, lat);
    // starts while busy are ignored
    measure(16, 8, 0, 1, lat);
    // input held low: timeout exactly TIMEOUT cycles after ARM entry
    measure(0, 0, 2, 0, lat);
    check("timeout_latency", lat, TIMEOUT);
    // one rise, then stuck high
    measure(0, 0, 3, 0, lat);

    // reset mid-measurement
    pat_p = 16; pat_h = 8; pat_mode = 0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_pre_reset", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_period", period, 0);
    check("arst_high_time", high_time, 0);
    check("arst_pass", pass, 0);
    check("arst_timeout", timeout, 0);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    measure(16, 8, 0, 0, lat);

    // randomized waveforms
    for (int i = 0; i < 12; i++) begin
      int p, h;
      p = $urandom_range(28, 3);
      h = $urandom_range(p - 1, 1);
      measure(p, h, 0, 0, lat);
    end

    repeat (10) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
